// File: rtl/stopwatch_ctrl.sv
// Stopwatch front-end: button synchronize/debounce, IDLE/RUN/PAUSE control,
// tick prescaler and the one-cycle clear pulse for the digit counter chain.
module stopwatch_ctrl #(
    parameter int TICK_DIV        = 1_000_000,
    parameter int DIV_WID         = 20,
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int DB_WID          = 19
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_run,
    input  logic btn_clear,
    output logic increment,
    output logic clear,
    output logic running,
    output logic paused
);

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] RUN   = 2'b01;
    localparam logic [1:0] PAUSE = 2'b10;

    localparam logic [DB_WID-1:0]  DB_LAST  = DB_WID'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_WID-1:0] DIV_LAST = DIV_WID'(TICK_DIV - 1);

    // Bit 0 carries the run button, bit 1 the clear button.
    logic [1:0]        btn_raw;
    logic [1:0]        sync_p0;
    logic [1:0]        sync_p1;
    logic [1:0]        level;
    logic [1:0]        level_prev;
    logic [1:0]        press;
    logic [DB_WID-1:0] db_cnt [2];

    logic [1:0]         state;
    logic [1:0]         state_next;
    logic               clear_next;
    logic [DIV_WID-1:0] div_cnt;

    assign btn_raw = {btn_clear, btn_run};

    // Stage p0/p1: two-flop synchronizer, then per-button debounce on sync_p1
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0    <= '0;
            sync_p1    <= '0;
            level      <= '0;
            level_prev <= '0;
            db_cnt[0]  <= '0;
            db_cnt[1]  <= '0;
        end else begin
            sync_p0    <= btn_raw;
            sync_p1    <= sync_p0;
            level_prev <= level;
            for (int i = 0; i < 2; i++) begin
                if (sync_p1[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    level[i]  <= sync_p1[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_WID'(1);
                end
            end
        end
    end

    assign press = level & ~level_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Clear has priority outside RUN; inside RUN only the run button matters.
    always_comb begin
        state_next = state;
        clear_next = 1'b0;
        case (state)
            IDLE: begin
                if (press[1]) begin
                    clear_next = 1'b1;
                end else if (press[0]) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (press[0]) begin
                    state_next = PAUSE;
                end
            end
            PAUSE: begin
                if (press[1]) begin
                    state_next = IDLE;
                    clear_next = 1'b1;
                end else if (press[0]) begin
                    state_next = RUN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        running = (state == RUN);
        paused  = (state == PAUSE);
    end

    // Prescaler follows the current state, so a wrap in the last RUN cycle still ticks.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt   <= '0;
            increment <= 1'b0;
            clear     <= 1'b0;
        end else begin
            clear     <= clear_next;
            increment <= 1'b0;
            if (state == RUN) begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt   <= '0;
                    increment <= 1'b1;
                end else begin
                    div_cnt <= div_cnt + DIV_WID'(1);
                end
            end else if (state_next == IDLE) begin
                div_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: vector table, timed corner sequences and random
// button activity checked against a cycle-level behavioural model.
module tb_stopwatch_ctrl;

    localparam int TD = 4;
    localparam int DB = 3;
    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_run = 1'b0;
    logic btn_clear = 1'b0;
    logic increment, clear, running, paused;
    logic [3:0] outs;

    int n_checks = 0;
    int n_fail = 0;
    int step = 0;

    typedef struct {
        bit       rst;
        bit       run;
        bit       clr;
        bit [3:0] exp;   // {increment, clear, running, paused}
    } vec_t;
    vec_t vecs[$];

    bit run_pat[85];
    bit clr_pat[85];
    int run_st[9] = '{0, 6, 12, 28, 40, 46, 52, 60, 72};
    int clr_st[3] = '{20, 34, 52};
    bit bpat[16];

    // Behavioural model: delay line, window of the last DB synchronized samples,
    // modular tick phase.
    bit m_sync1[2];
    bit m_s[2];
    bit m_lvl[2];
    bit m_lvl_prev[2];
    bit m_hist[2][DB];
    int m_st;
    int m_phase;
    bit m_inc;
    bit m_clr;

    assign outs = {increment, clear, running, paused};

    stopwatch_ctrl #(
        .TICK_DIV(TD),
        .DIV_WID(3),
        .DEBOUNCE_CYCLES(DB),
        .DB_WID(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_run(btn_run),
        .btn_clear(btn_clear),
        .increment(increment),
        .clear(clear),
        .running(running),
        .paused(paused)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step=%0d got=%b expected=%b", name, step, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {3'b000, act}, {3'b000, exp});
    endtask

    task automatic model_step(input bit r, input bit br, input bit bc);
        bit rp, cp, flip, raw;
        int ns;
        if (r) begin
            for (int b = 0; b < 2; b++) begin
                m_sync1[b] = 0; m_s[b] = 0; m_lvl[b] = 0; m_lvl_prev[b] = 0;
                for (int k = 0; k < DB; k++) m_hist[b][k] = 0;
            end
            m_st = S_IDLE; m_phase = 0; m_inc = 0; m_clr = 0;
        end else begin
            rp = m_lvl[0] && !m_lvl_prev[0];
            cp = m_lvl[1] && !m_lvl_prev[1];
            ns = m_st;
            m_clr = 0;
            case (m_st)
                S_IDLE:  if (cp) m_clr = 1; else if (rp) ns = S_RUN;
                S_RUN:   if (rp) ns = S_PAUSE;
                default: if (cp) begin ns = S_IDLE; m_clr = 1; end else if (rp) ns = S_RUN;
            endcase
            m_inc = 0;
            if (m_st == S_RUN) begin
                m_phase = (m_phase + 1) % TD;
                m_inc = (m_phase == 0);
            end else if (ns == S_IDLE) begin
                m_phase = 0;
            end
            for (int b = 0; b < 2; b++) begin
                raw = (b == 0) ? br : bc;
                m_lvl_prev[b] = m_lvl[b];
                for (int k = DB - 1; k > 0; k--) m_hist[b][k] = m_hist[b][k-1];
                m_hist[b][0] = m_s[b];
                flip = 1;
                for (int k = 0; k < DB; k++) if (m_hist[b][k] == m_lvl[b]) flip = 0;
                if (flip) m_lvl[b] = !m_lvl[b];
                m_s[b] = m_sync1[b];
                m_sync1[b] = raw;
            end
            m_st = ns;
        end
    endtask

    task automatic cycle(input bit r, input bit br, input bit bc);
        reset = r; btn_run = br; btn_clear = bc;
        @(posedge clk);
        model_step(r, br, bc);
        #1;
        chk("model", outs, {m_inc, m_clr, m_st == S_RUN, m_st == S_PAUSE});
    endtask

    initial begin
        int pause_incs;
        int tail_incs;
        bit rr, rc;

        // Reset with toggling buttons, then a 10-cycle run hold from E0.
        vecs.push_back('{1'b1, 1'b1, 1'b0, 4'b0000});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 4'b0000});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 4'b0000});
        for (int i = 0; i < 18; i++)
            vecs.push_back('{1'b0, (i < 10), 1'b0,
                             {(i >= 9 && (i - 9) % 4 == 0), 1'b0, (i >= 5), 1'b0}});
        foreach (vecs[i]) begin
            step = i;
            cycle(vecs[i].rst, vecs[i].run, vecs[i].clr);
            chk("vector", outs, vecs[i].exp);
        end

        // Bounce rejection from a fresh reset.
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        bpat = '{1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 16; i++) begin
            step = 100 + i;
            cycle(0, bpat[i], 0);
            chk("bounce", {2'b00, running, paused}, 4'b0000);
        end

        // Timed sequence: pause/resume phase, clear handling, tick at pause boundary.
        foreach (run_st[i]) for (int k = 0; k < 3; k++) run_pat[run_st[i] + k] = 1;
        foreach (clr_st[i]) for (int k = 0; k < 3; k++) clr_pat[clr_st[i] + k] = 1;
        pause_incs = 0;
        tail_incs = 0;
        for (int j = 0; j < 85; j++) begin
            step = 200 + j;
            cycle(0, run_pat[j], clr_pat[j]);
            if (j >= 11 && j <= 16) pause_incs += int'(increment);
            if (j >= 78) tail_incs += int'(increment);
            case (j)
                5:  chk1("start_running", running, 1);
                9:  chk1("first_tick", increment, 1);
                10: chk1("no_tick_after_first", increment, 0);
                11: begin chk1("pause_entered", paused, 1); chk1("pause_no_tick", increment, 0); end
                16: chk("pause_quiet", 4'(pause_incs), 4'd0);
                17: chk1("resume_running", running, 1);
                18: chk1("resume_not_yet", increment, 0);
                19: chk1("resume_phase_tick", increment, 1);
                25: begin chk1("clear_in_run_ignored", running, 1); chk1("no_clear_in_run", clear, 0); end
                27: chk1("tick_after_clear_ignored", increment, 1);
                33: chk1("pause_again", paused, 1);
                38: chk1("still_paused", paused, 1);
                39: begin chk1("clear_pulse", clear, 1); chk1("paused_falls", paused, 0); end
                40: chk1("clear_one_cycle", clear, 0);
                45: chk1("restart_running", running, 1);
                48: chk1("restart_not_yet", increment, 0);
                49: chk1("restart_tick", increment, 1);
                51: chk1("pause_third", paused, 1);
                57: begin chk1("simul_clear", clear, 1); chk1("simul_paused", paused, 0);
                          chk1("simul_running", running, 0); end
                58: chk1("simul_clear_once", clear, 0);
                62: chk1("simul_run_dropped", running, 0);
                65: chk1("run_for_boundary", running, 1);
                73: chk1("boundary_prior_tick", increment, 1);
                76: begin chk1("boundary_gap", increment, 0); chk1("boundary_still_run", running, 1); end
                77: begin chk1("boundary_tick", increment, 1); chk1("boundary_paused", paused, 1); end
                84: chk("boundary_tail_quiet", 4'(tail_incs), 4'd0);
                default: ;
            endcase
        end

        // Random button activity with occasional reset, against the model.
        rr = 0;
        rc = 0;
        for (int i = 0; i < 4000; i++) begin
            step = 1000 + i;
            if ($urandom_range(0, 5) == 0) rr = !rr;
            if ($urandom_range(0, 5) == 0) rc = !rc;
            cycle($urandom_range(0, 299) == 0, rr, rc);
            chk1("clear_inc_exclusive", clear & increment, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
